// File: rtl/myriadrf_rx_pkg.sv
// Shared widths and lane formatting for the MyriadRF RX sample FIFO.
// A 12-bit sample becomes a 16-bit lane, either sign-extended or left-justified.
package myriadrf_rx_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int LANE_W     = 16;
    localparam int IQ_W       = 24;
    localparam int WORD_W     = 32;
    localparam int DROP_CNT_W = 16;

    function automatic logic [LANE_W-1:0] format_lane(
        input logic [SAMPLE_W-1:0] sample,
        input logic                sign_ext
    );
        if (sign_ext)
            return {{(LANE_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
        else
            return {sample, {(LANE_W-SAMPLE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/myriadrf_rx_fifo_mem.sv
// Simple dual-port storage, 2**AW x DW, registered read.
// The read register doubles as the FIFO output data register.
module myriadrf_rx_fifo_mem
    import myriadrf_rx_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = WORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_reg [2**AW];
    logic [DW-1:0] rd_data_reg;

    // Contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_reg[wr_addr] <= wr_data;
    end

    // Old-data read semantics: a same-address write (full + pop) returns the stored word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_reg <= '0;
        else if (rd_en)
            rd_data_reg <= mem_reg[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/myriadrf_rx_fifo.sv
// RX sample FIFO: accepts every 24-bit IQ sample or drops it with accounting,
// and presents 32-bit two-lane words through a valid/ready output register.
module myriadrf_rx_fifo
    import myriadrf_rx_pkg::*;
#(
    parameter int AW       = 9,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [IQ_W-1:0]       s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [WORD_W-1:0]     m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [AW:0]           level_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    logic [AW:0]             wr_ptr_reg, rd_ptr_reg;
    logic                    m_valid_reg;
    logic                    overflow_reg;
    logic [DROP_CNT_W-1:0]   drop_cnt_reg;
    logic [WORD_W-1:0]       wr_word;
    logic                    empty, full, pop, accept, wr_en, drop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign wr_word[gi*LANE_W +: LANE_W] =
                format_lane(s_data_i[gi*SAMPLE_W +: SAMPLE_W], SIGN_EXT);
        end
    endgenerate

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop    = !empty && (!m_valid_reg || m_ready_i);
    assign accept = s_valid_i && enable_i;
    assign wr_en  = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    myriadrf_rx_fifo_mem #(
        .AW (AW),
        .DW (WORD_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (m_data_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            m_valid_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                m_valid_reg <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (overflow_clr_i)
                drop_cnt_reg <= DROP_CNT_W'(1);
            else if (drop_cnt_reg != '1)
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end else if (overflow_clr_i) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end
    end

    assign s_ready_o  = 1'b1;
    assign m_valid_o  = m_valid_reg;
    assign level_o    = wr_ptr_reg - rd_ptr_reg;
    assign overflow_o = overflow_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: doc/myriadrf_rx_fifo.md
Name: myriadrf_rx_fifo

Overview:
- Sits directly downstream of the MyriadRF RX interface.
- Consumes its 24-bit IQ sample stream. The upstream stage cannot stall, so this block must always accept or explicitly drop.
- Buffers samples in a synchronous FIFO and reformats each sample into a 32-bit word of two 16-bit lanes for the SoC DMA/bus side.
- Reports overflow through a sticky flag and a saturating drop counter.

Parameters:
- AW, 9, FIFO address width; storage depth is 2**AW entries.
- SIGN_EXT, 1, lane format: 1 = sign-extend 12-bit to 16-bit; 0 = left-justify (sample in bits [15:4], bits [3:0] zero).

Ports:
- clk  input  1  sole clock
- rst  input  1  asynchronous, active-high reset
- enable_i  input  1  capture enable; when low, input samples are ignored
- s_data_i  input  24  sample; [23:12] = lane A, [11:0] = lane B
- s_valid_i  input  1  sample valid
- s_ready_o  output  1  constant 1; upstream never stalls
- m_data_o  output  32  [31:16] = lane A formatted, [15:0] = lane B formatted
- m_valid_o  output  1  output word valid
- m_ready_i  input  1  downstream accepts word
- level_o  output  AW+1  entries in storage, excluding the output register
- overflow_o  output  1  sticky: at least one sample dropped
- overflow_clr_i  input  1  single-cycle pulse; clears overflow_o and drop_cnt_o
- drop_cnt_o  output  16  dropped-sample count, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, released synchronously to clk):
  - m_valid_o = 0, m_data_o = 0, level_o = 0, overflow_o = 0, drop_cnt_o = 0.
  - Read and write pointers = 0.
  - Any sample in flight is discarded.
- Write:
  - Occurs at a clk edge when s_valid_i & enable_i & (not full, or a storage read occurs in the same cycle).
  - Formatting is applied before storage; storage width is 32 bits.
- Storage read (pop):
  - Occurs when level_o != 0 and (m_valid_o == 0 or m_ready_i == 1).
  - The popped word loads m_data_o and sets m_valid_o on the same edge.
- Output register:
  - If m_valid_o & m_ready_i and no pop occurs, m_valid_o clears.
  - m_data_o holds while m_valid_o & !m_ready_i.
- Latency: with empty storage and idle output, a sample written at edge k appears on m_valid_o/m_data_o after edge k+1. Steady-state throughput is 1 word/cycle.
- Full condition: level_o == 2**AW. Total capacity = 2**AW + 1 words, counting the output register.
- Drop:
  - Occurs when s_valid_i & enable_i & full & no pop in that cycle.
  - The sample is discarded, overflow_o is set, and drop_cnt_o increments unless already 16'hFFFF.
- Full with a simultaneous pop: the write is accepted, no drop occurs, and level_o is unchanged.
- enable_i low:
  - Samples are ignored and not counted as drops.
  - Draining continues normally.
  - Toggling enable_i mid-stream never splits a word, because each sample is atomic.
- overflow_clr_i:
  - Clears overflow_o to 0 and drop_cnt_o to 0.
  - If a drop occurs in the same cycle, the drop wins: overflow_o = 1, drop_cnt_o = 1.
- Pointers: AW+1 bits with natural wrap; full/empty are derived from the MSB compare.
- Arithmetic:
  - SIGN_EXT = 1: lane = {{4{x[11]}}, x}.
  - SIGN_EXT = 0: lane = {x, 4'b0}.

Decomposition:
- Package myriadrf_rx_pkg:
  - constants SAMPLE_W = 12, LANE_W = 16, IQ_W = 24, WORD_W = 32
  - DROP_CNT_W = 16
  - function format_lane(sample, sign_ext)
- Sub-module myriadrf_rx_fifo_mem: simple dual-port RAM, 2**AW x 32, registered read, one write port and one read port, no reset on contents. Inferable as block RAM.

Test Plan:
- Reset, then single sample 24'h800_7FF with m_ready_i = 1 and SIGN_EXT = 1 -> after edge k+1: m_valid_o = 1 for one cycle, m_data_o = 32'hF800_07FF. level_o stays 0 afterwards.
- Same sample with SIGN_EXT = 0 -> m_data_o = 32'h8000_7FF0.
- AW = 2, m_ready_i = 0, write 7 consecutive samples -> first 5 retained (level_o = 4, plus the output register), 2 dropped. overflow_o = 1, drop_cnt_o = 2. Then raise m_ready_i -> 5 words out in order, no gaps.
- Full with m_ready_i = 1 and continuous input -> no drops; level_o constant at 4; output sequence equals input sequence.
- overflow_clr_i pulsed in the same cycle as a drop -> overflow_o = 1, drop_cnt_o = 1. Pulse alone next cycle -> both return to 0.
- Mid-stream sequence:
  - enable_i = 0 for 10 cycles -> no writes and no drop counts; FIFO drains fully.
  - Then rst asserted mid-burst -> m_valid_o = 0 and level_o = 0 immediately, without waiting for a clk edge.
